// File: rtl/guess_entry_pkg.sv
// Shared constants, state encoding and letter arithmetic for the guess_entry block.
package guess_entry_pkg;

  localparam int unsigned WordLen = 5;
  localparam int unsigned LetterW = 5;
  localparam int unsigned CursorW = 3;
  localparam int unsigned WordW   = WordLen * LetterW;

  localparam logic [LetterW-1:0] Blank   = 5'd31;
  localparam logic [LetterW-1:0] LetterA = 5'd0;
  localparam logic [LetterW-1:0] LetterZ = 5'd25;

  localparam logic [CursorW-1:0] CursorMax = CursorW'(WordLen - 1);

  typedef logic [0:0] state_t;
  localparam state_t StEdit   = 1'b0;
  localparam state_t StSubmit = 1'b1;

  typedef logic [WordLen-1:0][LetterW-1:0] word_t;

  // Blank and Z both roll over to A.
  function automatic logic [LetterW-1:0] letter_inc(input logic [LetterW-1:0] c);
    return (c >= LetterZ) ? LetterA : c + 1'b1;
  endfunction

  // Blank and A both roll back to Z.
  function automatic logic [LetterW-1:0] letter_dec(input logic [LetterW-1:0] c);
    return ((c == LetterA) || (c > LetterZ)) ? LetterZ : c - 1'b1;
  endfunction

endpackage

// File: rtl/guess_entry_if.sv
// Valid/ready guess channel from guess_entry (master) to the game core (slave).
interface guess_entry_if;
  import guess_entry_pkg::*;

  logic             guess_valid;
  logic             guess_ready;
  logic [WordW-1:0] guess_word;

  modport master (
    output guess_valid,
    output guess_word,
    input  guess_ready
  );

  modport slave (
    input  guess_valid,
    input  guess_word,
    output guess_ready
  );

endinterface

// File: rtl/guess_entry_btn_edge.sv
// Rising-edge detector for one button; the event is combinational, so no latency is added.
module guess_entry_btn_edge (
  input  logic clk_i,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  logic btn_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
    end
  end

  assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/guess_entry.sv
// Button-driven five-letter guess editor with a valid/ready hand-off to the game core.
// Define GUESS_ENTRY_EDGE_EN to turn held button levels into single rising-edge events.
module guess_entry
  import guess_entry_pkg::*;
(
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                btn_up_i,
  input  logic                btn_down_i,
  input  logic                btn_enter_i,
  input  logic                btn_del_i,
  input  logic                lock_i,
  guess_entry_if.master       guess_if,
  output logic [CursorW-1:0]  cursor_o,
  output logic [LetterW-1:0]  cur_letter_o
);

  logic ev_up, ev_down, ev_enter, ev_del;

`ifdef GUESS_ENTRY_EDGE_EN
  guess_entry_btn_edge u_edge_up (
    .clk_i  (clk_sys),
    .rst_n  (rst_n),
    .btn_i  (btn_up_i),
    .rise_o (ev_up)
  );
  guess_entry_btn_edge u_edge_down (
    .clk_i  (clk_sys),
    .rst_n  (rst_n),
    .btn_i  (btn_down_i),
    .rise_o (ev_down)
  );
  guess_entry_btn_edge u_edge_enter (
    .clk_i  (clk_sys),
    .rst_n  (rst_n),
    .btn_i  (btn_enter_i),
    .rise_o (ev_enter)
  );
  guess_entry_btn_edge u_edge_del (
    .clk_i  (clk_sys),
    .rst_n  (rst_n),
    .btn_i  (btn_del_i),
    .rise_o (ev_del)
  );
`else
  assign ev_up    = btn_up_i;
  assign ev_down  = btn_down_i;
  assign ev_enter = btn_enter_i;
  assign ev_del   = btn_del_i;
`endif

  state_t               state_q, state_d;
  word_t                slots_q, slots_d;
  logic [CursorW-1:0]   cursor_q, cursor_d;
  logic [LetterW-1:0]   cur_letter_q, cur_letter_d;
  logic [LetterW-1:0]   active;

  assign active = slots_q[cursor_q];

  always_comb begin
    state_d  = state_q;
    slots_d  = slots_q;
    cursor_d = cursor_q;
    unique case (state_q)
      StEdit: begin
        if (!lock_i) begin
          // Priority: del > enter > up/down; up and down together cancel.
          if (ev_del) begin
            if (active != Blank) begin
              slots_d[cursor_q] = Blank;
            end else if (cursor_q != '0) begin
              cursor_d          = cursor_q - 1'b1;
              slots_d[cursor_d] = Blank;
            end
          end else if (ev_enter) begin
            if (active != Blank) begin
              if (cursor_q == CursorMax) begin
                state_d = StSubmit;
              end else begin
                cursor_d = cursor_q + 1'b1;
              end
            end
          end else if (ev_up && !ev_down) begin
            slots_d[cursor_q] = letter_inc(active);
          end else if (ev_down && !ev_up) begin
            slots_d[cursor_q] = letter_dec(active);
          end
        end
      end
      StSubmit: begin
        // Word is frozen here; lock cannot withdraw the offer.
        if (guess_if.guess_ready) begin
          state_d  = StEdit;
          slots_d  = {WordLen{Blank}};
          cursor_d = '0;
        end
      end
      default: state_d = StEdit;
    endcase
    cur_letter_d = slots_d[cursor_d];
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEdit;
      slots_q      <= {WordLen{Blank}};
      cursor_q     <= '0;
      cur_letter_q <= Blank;
    end else begin
      state_q      <= state_d;
      slots_q      <= slots_d;
      cursor_q     <= cursor_d;
      cur_letter_q <= cur_letter_d;
    end
  end

  assign guess_if.guess_valid = (state_q == StSubmit);
  assign guess_if.guess_word  = slots_q;
  assign cursor_o             = cursor_q;
  assign cur_letter_o         = cur_letter_q;

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry: letter wrap, enter/delete rules, priority, lock,
// handshake and asynchronous reset.
module tb_guess_entry;
  import guess_entry_pkg::*;

  logic               clk_sys;
  logic               rst_n;
  logic               btn_up, btn_down, btn_enter, btn_del, lock;
  logic [CursorW-1:0] cursor;
  logic [LetterW-1:0] cur_letter;

  int unsigned n_checks;
  int unsigned n_bad;

  localparam logic [31:0] AllBlank = 32'h01FF_FFFF;

  guess_entry_if gif ();

  guess_entry dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .btn_up_i     (btn_up),
    .btn_down_i   (btn_down),
    .btn_enter_i  (btn_enter),
    .btn_del_i    (btn_del),
    .lock_i       (lock),
    .guess_if     (gif.master),
    .cursor_o     (cursor),
    .cur_letter_o (cur_letter)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One-cycle button pulse; outputs are sampled on the negedge that ends it.
  task automatic press(input logic up, input logic down, input logic enter, input logic del);
    @(negedge clk_sys);
    btn_up = up; btn_down = down; btn_enter = enter; btn_del = del;
    @(negedge clk_sys);
    btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0; btn_del = 1'b0;
  endtask

  task automatic ups(input int n);
    for (int i = 0; i < n; i++) press(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  logic [31:0] hello;

  initial begin
    n_checks = 0; n_bad = 0;
    btn_up = 0; btn_down = 0; btn_enter = 0; btn_del = 0; lock = 0;
    gif.guess_ready = 1'b0;
    rst_n = 1'b0;
    #23 rst_n = 1'b1;
    @(negedge clk_sys);

    check("rst_valid", 32'(gif.guess_valid), 32'd0);
    check("rst_cursor", 32'(cursor), 32'd0);
    check("rst_letter", 32'(cur_letter), 32'd31);
    check("rst_word", 32'(gif.guess_word), AllBlank);

    // Letter wrap
    ups(1);
    check("wrap_first_up", 32'(cur_letter), 32'd0);
    ups(25);
    check("wrap_z", 32'(cur_letter), 32'd25);
    ups(1);
    check("wrap_z_to_a", 32'(cur_letter), 32'd0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_a_to_z", 32'(cur_letter), 32'd25);

    // Blank enter
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check("del_to_blank", 32'(cur_letter), 32'd31);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("blank_enter_cursor", 32'(cursor), 32'd0);
    ups(1);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("enter_cursor1", 32'(cursor), 32'd1);
    check("slot0_a", 32'(gif.guess_word[4:0]), 32'd0);

    // Delete
    ups(1);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    ups(4);
    check("del_pre_cursor", 32'(cursor), 32'd2);
    check("del_pre_letter", 32'(cur_letter), 32'd3);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check("del_clear_letter", 32'(cur_letter), 32'd31);
    check("del_clear_cursor", 32'(cursor), 32'd2);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check("del_back_cursor", 32'(cursor), 32'd1);
    check("del_back_slot1", 32'(gif.guess_word[9:5]), 32'd31);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check("del_back_cursor0", 32'(cursor), 32'd0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check("del_at0_cursor", 32'(cursor), 32'd0);
    check("del_at0_word", 32'(gif.guess_word), AllBlank);

    // Simultaneous events and lock
    press(1'b1, 1'b1, 1'b0, 1'b0);
    check("up_down_cancel", 32'(cur_letter), 32'd31);
    ups(1);
    press(1'b1, 1'b0, 1'b0, 1'b1);
    check("del_beats_up", 32'(cur_letter), 32'd31);
    press(1'b1, 1'b0, 1'b1, 1'b0);
    check("enter_beats_up", 32'(cur_letter), 32'd31);
    check("enter_beats_up_cur", 32'(cursor), 32'd0);
    lock = 1'b1;
    ups(3);
    check("lock_ignores_up", 32'(cur_letter), 32'd31);
    lock = 1'b0;
    gif.guess_ready = 1'b1;
    ups(1);
    check("ready_in_edit", 32'(gif.guess_valid), 32'd0);
    gif.guess_ready = 1'b0;
    press(1'b0, 1'b0, 1'b0, 1'b1);

    // Full word HELLO and handshake
    ups(8);  press(1'b0, 1'b0, 1'b1, 1'b0);
    ups(5);  press(1'b0, 1'b0, 1'b1, 1'b0);
    ups(12); press(1'b0, 1'b0, 1'b1, 1'b0);
    ups(12); press(1'b0, 1'b0, 1'b1, 1'b0);
    ups(15);
    check("hello_pre_valid", 32'(gif.guess_valid), 32'd0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    hello = {7'd0, 5'd14, 5'd11, 5'd11, 5'd4, 5'd7};
    check("hello_valid", 32'(gif.guess_valid), 32'd1);
    check("hello_word", 32'(gif.guess_word), hello);
    for (int i = 0; i < 10; i++) begin
      lock = (i >= 5);
      press(i[0], ~i[0], 1'b0, i[0]);
    end
    lock = 1'b0;
    check("hold_valid", 32'(gif.guess_valid), 32'd1);
    check("hold_word", 32'(gif.guess_word), hello);
    check("hold_cursor", 32'(cursor), 32'd4);
    @(negedge clk_sys);
    gif.guess_ready = 1'b1;
    @(negedge clk_sys);
    gif.guess_ready = 1'b0;
    check("hs_valid", 32'(gif.guess_valid), 32'd0);
    check("hs_cursor", 32'(cursor), 32'd0);
    check("hs_word", 32'(gif.guess_word), AllBlank);
    check("hs_letter", 32'(cur_letter), 32'd31);
    ups(1);
    check("post_hs_up", 32'(cur_letter), 32'd0);

    // Asynchronous reset during SUBMIT
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b0, 1'b1, 1'b0);
      ups(1);
    end
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_pre_valid", 32'(gif.guess_valid), 32'd1);
    check("rst_pre_word", 32'(gif.guess_word), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(gif.guess_valid), 32'd0);
    check("async_rst_cursor", 32'(cursor), 32'd0);
    check("async_rst_word", 32'(gif.guess_word), AllBlank);
    check("async_rst_letter", 32'(cur_letter), 32'd31);
    @(negedge clk_sys);
    rst_n = 1'b1;

    // Held button: one event in edge mode, one per cycle otherwise
    @(negedge clk_sys);
    btn_up = 1'b1;
    repeat (100) @(negedge clk_sys);
    btn_up = 1'b0;
    @(negedge clk_sys);
`ifdef GUESS_ENTRY_EDGE_EN
    check("held_up", 32'(cur_letter), 32'd0);
`else
    check("held_up", 32'(cur_letter), 32'd21);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/guess_entry.md
# guess_entry

Converts debounced button pulses into a five-letter Wordle guess. Sits between the per-button debouncers and the game logic. Lets the player cycle the letter at a cursor, advance, and delete. When the word is complete, it presents the word to the game core over a valid/ready handshake and holds it stable until accepted.

## Interface
- WORD_LEN, 5, letters per guess
- LETTER_W, 5, bits per letter code (0..25 = A..Z)
- clk_sys  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- btn_up  in  1  debouncer output; next letter
- btn_down  in  1  debouncer output; previous letter
- btn_enter  in  1  debouncer output; advance cursor / submit
- btn_del  in  1  debouncer output; delete
- lock  in  1  game over; all buttons ignored while high
- guess_valid  out  1  completed guess presented
- guess_ready  in  1  game core accepts guess
- guess_word  out  WORD_LEN*LETTER_W  slot 0 in LSBs
- cursor  out  3  active slot index
- cur_letter  out  LETTER_W  letter in active slot (BLANK if empty)

## Operation
- Letter codes: 0..25 = A..Z; BLANK = 31. All slots reset to BLANK.
- States:
  - EDIT (reset state)
  - SUBMIT
- Button events are taken only in EDIT with lock low.
- Simultaneous events resolve by priority: del > enter > up/down. If up and down are both active, no change.
- up:
  - BLANK → A (0)
  - Z (25) → A
  - otherwise +1
- down:
  - BLANK → Z
  - A → Z
  - otherwise −1
- enter:
  - Active slot BLANK → ignored.
  - cursor < WORD_LEN−1 → cursor+1.
  - cursor = WORD_LEN−1 → go to SUBMIT.
- del:
  - Active slot non-BLANK → set it to BLANK; cursor unchanged.
  - Active slot BLANK and cursor > 0 → cursor−1, and that slot becomes BLANK.
  - cursor = 0 and slot BLANK → ignored.
- SUBMIT:
  - guess_valid = 1; guess_word is held constant; all buttons are ignored.
  - On guess_valid & guess_ready: all slots → BLANK, cursor → 0, return to EDIT.
- lock high in SUBMIT does not withdraw guess_valid. The handshake must complete.
- Arithmetic is modulo 26 on letter codes. The cursor never exceeds WORD_LEN−1 and never goes below 0.

## Timing
- Reset values:
  - guess_valid = 0
  - cursor = 0
  - cur_letter = 31
  - guess_word = all slots 31
  - state = EDIT
- All outputs are registered.
- A button event sampled at edge N is visible on the outputs after edge N.
- The enter that completes the word raises guess_valid on the following cycle.
- The handshake completes at the edge where valid & ready are both high. guess_valid is 0 on the next cycle, and the block accepts button events from that cycle onward.
- guess_ready is ignored while guess_valid is low.
- rst_n assertion at any time, including mid-SUBMIT, returns immediately to reset values. No guess is delivered.

## Configuration
- GUESS_ENTRY_EDGE_EN defined:
  - Each button input is registered.
  - An event is the rising edge (btn & ~btn_q). A level held high counts once until released.
  - No added latency.
- GUESS_ENTRY_EDGE_EN undefined:
  - Every cycle a button input is high is an event.
  - This relies on the debouncer emitting single-cycle pulses.

## Structure
- guess_entry_pkg holds:
  - LETTER_W
  - BLANK = 5'd31
  - LETTER_Z = 5'd25
  - state enum {EDIT, SUBMIT}
- One sub-module, btn_edge: a per-button rising-edge detector with async active-low reset. It is instantiated four times when GUESS_ENTRY_EDGE_EN is defined; otherwise it is bypassed.

## Test plan
- **Letter wrap:** after reset, 1 up → cur_letter 0. 25 more ups → 25. 1 more up → 0. 1 down → 25.
- **Blank enter:** enter with the slot BLANK → cursor stays 0. Then up, enter → cursor 1, guess_word[4:0] = 0.
- **Full word and handshake:** enter letters H,E,L,L,O (7,4,11,11,14) with enters between them, then a final enter → guess_valid = 1 and guess_word = {14,11,11,4,7}. Hold guess_ready low for 10 cycles → word stable and buttons ignored. Pulse ready → next cycle valid = 0, cursor 0, all slots 31.
- **Delete:** at cursor 2 with slot 2 = 3, del → slot 2 = 31, cursor 2. Del again → cursor 1, slot 1 = 31. At cursor 0 with slot BLANK, del → no change.
- **Simultaneous and lock:**
  - up+down in the same cycle → no change.
  - del+up → delete only.
  - lock high → ups are ignored.
- **Reset and edge mode:**
  - rst_n low during SUBMIT → guess_valid 0 with reset values asynchronously.
  - With GUESS_ENTRY_EDGE_EN, btn_up held high 100 cycles → exactly one increment.
